// File: rtl/arctan_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read arctan ROM among NREQ
// requesters; tags each read through two stages and returns a one-hot strobe.
module arctan_rom_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               busy
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   addr_q;
  logic            s1_valid_q;
  logic [IW-1:0]   s1_id_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;

  logic            gnt_any;
  logic [IW-1:0]   gnt_id;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin : arb
    int idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IW'(idx);
      end
    end
    if (rst) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_id == IW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_id + 1'b1;
      end
    end
  end

  assign req_ready = gnt_any ? (NREQ'(1) << gnt_id) : '0;
  assign rom_addr  = gnt_any ? req_addr[int'(gnt_id)*AW +: AW] : addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      addr_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= gnt_any;
      s1_id_q    <= gnt_id;
      if (gnt_any) begin
        addr_q <= rom_addr;
      end
      rsp_valid_q <= s1_valid_q ? (NREQ'(1) << s1_id_q) : '0;
      if (s1_valid_q) begin
        rsp_data_q <= rom_data;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = s1_valid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_arctan_rom_arbiter.sv
// Directed bench for arctan_rom_arbiter with a queue-based response
// scoreboard and a registered ROM model mem[a] = a[7:0] ^ 8'hA5.
module tb_arctan_rom_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_addr;
  logic [3:0]  req_ready;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  arctan_rom_arbiter #(.NREQ(4), .AW(16), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0] v;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic [15:0] last_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'hA5;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      fails++;
      $display("FAIL rsp_missing cyc=%0d got=none exp_cyc=%0d",
               cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (rsp_valid !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rsp_unexpected cyc=%0d got=%0h exp=0",
                 cyc, rsp_valid);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One cycle of requests; push expected response when a grant is expected.
  task automatic drive(input logic [3:0] v, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [15:0] a2,
                       input logic [15:0] a3, input logic [3:0] er,
                       input logic [15:0] ea, input logic [7:0] ed,
                       input bit push);
    exp_t e;
    req_valid = v;
    req_addr  = {a3, a2, a1, a0};
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(er));
    if (er != 4'b0000) begin
      chk("rom_addr_gnt", 32'(rom_addr), 32'(ea));
      last_addr = ea;
      if (push) begin
        e.v   = er;
        e.d   = ed;
        e.cyc = cyc + 2;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int bexp);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'h0);
    chk("rom_addr_hold", 32'(rom_addr), 32'(last_addr));
    if (bexp >= 0) chk("busy", 32'(busy), 32'(bexp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    rst       = 1'b1;
    req_valid = v;
    @(negedge clk);
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0000;
    last_addr = 16'h0000;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_addr  = '0;
    last_addr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    do_reset(4'b1111);

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    @(posedge clk);
    #1;

    // Single request from requester 1
    drive(4'b0010, 16'h0, 16'h0003, 16'h0, 16'h0,
          4'b0010, 16'h0003, 8'hA6, 1);
    idle(1);
    idle(1);
    idle(0);

    // All four valid from ptr=0
    do_reset(4'b0000);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] dv [4];
      dv = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
      drive(4'b1111, 16'h0, 16'h1, 16'h2, 16'h3,
            4'(1 << i), 16'(i), dv[i], 1);
    end
    repeat (3) idle(-1);

    // Fairness: 0 and 2 continuously valid
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        drive(4'b0101, 16'h20, 16'h0, 16'h22, 16'h0,
              4'b0001, 16'h20, 8'h85, 1);
      else
        drive(4'b0101, 16'h20, 16'h0, 16'h22, 16'h0,
              4'b0100, 16'h22, 8'h87, 1);
    end

    // Back-to-back requester 3, pointer wraps each grant
    for (int i = 0; i < 5; i++) begin
      logic [7:0] dv [5];
      dv = '{8'hB5, 8'hB4, 8'hB7, 8'hB6, 8'hB1};
      drive(4'b1000, 16'h0, 16'h0, 16'h0, 16'h10 + 16'(i),
            4'b1000, 16'h10 + 16'(i), dv[i], 1);
    end
    drive(4'b1001, 16'h30, 16'h0, 16'h0, 16'h33,
          4'b0001, 16'h30, 8'h95, 1);

    // Idle hold of rom_addr
    drive(4'b0010, 16'h0, 16'h00FF, 16'h0, 16'h0,
          4'b0010, 16'h00FF, 8'h5A, 1);
    idle(1);
    idle(1);
    idle(0);
    @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;

    // Reset mid-flight: the granted read must be dropped
    drive(4'b0100, 16'h0, 16'h0, 16'h40, 16'h0,
          4'b0100, 16'h40, 8'hE5, 0);
    do_reset(4'b0010);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_rsp", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    drive(4'b1010, 16'h0, 16'h0005, 16'h0, 16'h0050,
          4'b0010, 16'h0005, 8'hA0, 1);
    repeat (4) idle(-1);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
